// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) counter sequencer: runs a programmed number of full
// revolutions with hold/abort, one-hot phase decode and a done pulse.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_cycles,
  input  logic                 hold,
  input  logic                 abort,
  output logic [WIDTH-1:0]     count,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NPH = 2 * WIDTH;
  localparam logic [WIDTH-1:0] LAST = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   jnext;
  int unsigned        pc;
  int unsigned        pidx;

  assign jnext = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start) begin
          if (num_cycles != '0) begin
            rem_d   = num_cycles;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (!hold) begin
          count_d = jnext;
          // Revolution boundary: the last ring state wraps back to all-zero.
          if (count_q == LAST) begin
            if (rem_q == CNT_W'(1)) begin
              rem_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Phase index: popcount on the rising half of the ring, 2*WIDTH - popcount on the falling half.
  always_comb begin
    pc = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (count_q[i]) pc++;
    end
    pidx = count_q[WIDTH-1] ? (NPH - pc) : pc;
    phase = '0;
    if (busy) begin
      for (int unsigned i = 0; i < NPH; i++) begin
        if (pidx == i) phase[i] = 1'b1;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl (WIDTH=4, CNT_W=8): a step-index
// reference model pushes expected outputs each cycle, popped after the edge.
module tb_johnson_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_cycles;
  logic       hold;
  logic       abort;
  logic [3:0] count;
  logic [7:0] phase;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] count;
    logic [7:0] phase;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] jtab [8];
  int         m_step;
  logic       m_busy;
  int         m_rem;
  logic       m_done;
  int         busy_cnt;
  int         done_cnt;

  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .hold       (hold),
    .abort      (abort),
    .count      (count),
    .phase      (phase),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_step = 0;
    m_busy = 1'b0;
    m_rem  = 0;
    m_done = 1'b0;
  endtask

  // One clock: advance the model with the current inputs, push, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic nd;
    nd = 1'b0;
    if (!m_busy) begin
      m_step = 0;
      if (start) begin
        if (num_cycles == 8'd0) nd = 1'b1;
        else begin
          m_busy = 1'b1;
          m_rem  = int'(num_cycles);
        end
      end
    end else if (abort) begin
      m_busy = 1'b0;
      m_step = 0;
      m_rem  = 0;
    end else if (!hold) begin
      if (m_step == 7) begin
        m_step = 0;
        if (m_rem == 1) begin
          m_busy = 1'b0;
          nd = 1'b1;
        end
        m_rem = m_rem - 1;
      end else begin
        m_step = m_step + 1;
      end
    end
    m_done  = nd;
    e.count = jtab[m_step];
    e.phase = m_busy ? (8'd1 << m_step) : 8'd0;
    e.busy  = m_busy;
    e.done  = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".count"}, 32'(count), 32'(e.count));
    check({tag, ".phase"}, 32'(phase), 32'(e.phase));
    check({tag, ".busy"},  32'(busy),  32'(e.busy));
    check({tag, ".done"},  32'(done),  32'(e.done));
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_start(input string tag, input logic [7:0] n);
    start      = 1'b1;
    num_cycles = n;
    step(tag);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    jtab[0] = 4'b0000; jtab[1] = 4'b0001; jtab[2] = 4'b0011; jtab[3] = 4'b0111;
    jtab[4] = 4'b1111; jtab[5] = 4'b1110; jtab[6] = 4'b1100; jtab[7] = 4'b1000;
    model_reset();
    clear_counts();
    idle_inputs();
    num_cycles = 8'd0;
    rst = 1'b0;
    #12;
    check("rst.count", 32'(count), 32'h0);
    check("rst.phase", 32'(phase), 32'h0);
    check("rst.busy",  32'(busy),  32'h0);
    check("rst.done",  32'(done),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_idle("idle", 2);

    // Single revolution
    clear_counts();
    do_start("one", 8'd1);
    run_idle("one", 11);
    check("one.busy_len", 32'(busy_cnt), 32'd8);
    check("one.done_cnt", 32'(done_cnt), 32'd1);

    // Two revolutions with a 3-cycle hold at 0111
    clear_counts();
    do_start("hold", 8'd2);
    for (int i = 0; i < 20 && m_step != 3; i++) step("hold.adv");
    check("hold.reach", 32'(count), 32'b0111);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step("hold.frz");
    hold = 1'b0;
    run_idle("hold", 20);
    check("hold.busy_len", 32'(busy_cnt), 32'd19);
    check("hold.done_cnt", 32'(done_cnt), 32'd1);

    // Zero count: done only, never busy; hold/abort ignored in IDLE
    clear_counts();
    hold  = 1'b1;
    abort = 1'b1;
    do_start("zero", 8'd0);
    run_idle("zero", 3);
    check("zero.busy_len", 32'(busy_cnt), 32'd0);
    check("zero.done_cnt", 32'(done_cnt), 32'd1);

    // Abort together with hold at 1100
    clear_counts();
    do_start("abort", 8'd2);
    for (int i = 0; i < 20 && m_step != 6; i++) step("abort.adv");
    check("abort.reach", 32'(count), 32'b1100);
    abort = 1'b1;
    hold  = 1'b1;
    step("abort.hit");
    check("abort.busy_now", 32'(busy), 32'h0);
    run_idle("abort", 4);
    check("abort.done_cnt", 32'(done_cnt), 32'd0);
    clear_counts();
    do_start("after_abort", 8'd1);
    run_idle("after_abort", 10);
    check("after_abort.busy_len", 32'(busy_cnt), 32'd8);
    check("after_abort.done_cnt", 32'(done_cnt), 32'd1);

    // Start ignored while busy, then restart in the done cycle
    clear_counts();
    do_start("nostart", 8'd2);
    run_idle("nostart", 4);
    do_start("nostart.repulse", 8'd5);
    begin
      int guard;
      guard = 0;
      while (!done && guard < 40) begin
        step("nostart.run");
        guard++;
      end
      check("nostart.done_seen", 32'(done), 32'h1);
    end
    check("nostart.busy_len", 32'(busy_cnt), 32'd16);
    clear_counts();
    do_start("b2b", 8'd1);
    check("b2b.busy_rise", 32'(busy), 32'h1);
    run_idle("b2b", 10);
    check("b2b.busy_len", 32'(busy_cnt), 32'd8);
    check("b2b.done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-run
    clear_counts();
    do_start("arst", 8'd3);
    run_idle("arst", 5);
    check("arst.pre", 32'(count), 32'b1110);
    #2;
    rst = 1'b0;
    #1;
    check("arst.count", 32'(count), 32'h0);
    check("arst.phase", 32'(phase), 32'h0);
    check("arst.busy",  32'(busy),  32'h0);
    check("arst.done",  32'(done),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    clear_counts();
    run_idle("arst.after", 5);
    check("arst.done_cnt", 32'(done_cnt), 32'd0);

    // Maximum revolution count
    clear_counts();
    do_start("max", 8'd255);
    run_idle("max", 255 * 8 + 3);
    check("max.busy_len", 32'(busy_cnt), 32'd2040);
    check("max.done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
